// File: rtl/bcd_disp_pkg.sv
// Shared constants and state encoding for the treadmill BCD digit converter.
package bcd_disp_pkg;

  localparam logic [3:0]  BLANK_CODE = 4'hA;
  localparam logic [3:0]  OVF_CODE   = 4'hF;
  localparam int unsigned MAX_VAL    = 9999;
  localparam int unsigned NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_e;

endpackage

// File: rtl/bin_to_bcd_digits_if.sv
// Request/digit bundle between a value producer and the BCD digit converter.
interface bin_to_bcd_digits_if #(
  parameter int unsigned WIDTH = 14
);

  logic             start;
  logic [WIDTH-1:0] value_in;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [3:0]       dig3;
  logic [3:0]       dig2;
  logic [3:0]       dig1;
  logic [3:0]       dig0;

  modport master (
    output start, value_in,
    input  busy, done, overflow, dig3, dig2, dig1, dig0
  );

  modport slave (
    input  start, value_in,
    output busy, done, overflow, dig3, dig2, dig1, dig0
  );

endinterface

// File: rtl/dabble_nibble.sv
// Double-dabble nibble correction: add 3 when the BCD digit is 5 or more.
module dabble_nibble (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_digits.sv
// Iterative binary-to-BCD converter producing four display codes with
// leading-zero blanking and an overflow glyph; outputs change only on done.
module bin_to_bcd_digits
  import bcd_disp_pkg::*;
#(
  parameter int unsigned WIDTH         = 14,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  bin_to_bcd_digits_if.slave bus
);

  localparam int unsigned CW       = $clog2(WIDTH + 1);
  localparam logic [3:0]  RST_LEAD = BLANK_LEADING ? BLANK_CODE : 4'h0;

  state_e                     state_q, state_d;
  logic [CW-1:0]              count_q, count_d;
  logic [15:0]                bcd_q, bcd_d;
  logic [WIDTH-1:0]           bin_q, bin_d;
  logic                       ovf_pend_q, ovf_pend_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       overflow_q, overflow_d;
  logic [NUM_DIGITS-1:0][3:0] dig_q, dig_d;

  logic [15:0]                bcd_adj;
  logic [NUM_DIGITS-1:0][3:0] dig_fmt;
  logic                       blank3, blank2, blank1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
    dabble_nibble u_nib (
      .din  (bcd_q[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  // Blanking cascades from the thousands digit down; units always shown.
  always_comb begin
    blank3 = BLANK_LEADING && (bcd_q[15:12] == 4'd0);
    blank2 = blank3 && (bcd_q[11:8] == 4'd0);
    blank1 = blank2 && (bcd_q[7:4] == 4'd0);
    dig_fmt[3] = blank3 ? BLANK_CODE : bcd_q[15:12];
    dig_fmt[2] = blank2 ? BLANK_CODE : bcd_q[11:8];
    dig_fmt[1] = blank1 ? BLANK_CODE : bcd_q[7:4];
    dig_fmt[0] = bcd_q[3:0];
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    bcd_d      = bcd_q;
    bin_d      = bin_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    dig_d      = dig_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          bin_d      = bus.value_in;
          bcd_d      = '0;
          count_d    = CW'(WIDTH);
          ovf_pend_d = (32'(bus.value_in) > MAX_VAL);
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        // Carry out of the top BCD nibble is dropped; only reachable on overflow.
        {bcd_d, bin_d} = {bcd_adj[14:0], bin_q, 1'b0};
        count_d        = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        dig_d      = ovf_pend_q ? {NUM_DIGITS{OVF_CODE}} : dig_fmt;
        overflow_d = ovf_pend_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      bcd_q      <= '0;
      bin_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      dig_q      <= {RST_LEAD, RST_LEAD, RST_LEAD, 4'h0};
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      bcd_q      <= bcd_d;
      bin_q      <= bin_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      dig_q      <= dig_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;
  assign bus.dig3     = dig_q[3];
  assign bus.dig2     = dig_q[2];
  assign bus.dig1     = dig_q[1];
  assign bus.dig0     = dig_q[0];

endmodule
